// File: rtl/cpumc_arb.sv
// CPU memory-controller bus arbiter: lets the HCI debug port steal single bus
// cycles from the rp2a03 via RDY, and owns the bus outright during debug break.
module cpumc_arb #(
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic        clk_in,
  input  logic        nres_in,
  input  logic [15:0] cpu_a_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  cpu_d_in,
  output logic        cpu_rdy_out,
  input  logic        hci_active_in,
  input  logic        hci_req_in,
  input  logic [15:0] hci_a_in,
  input  logic        hci_r_nw_in,
  input  logic [7:0]  hci_d_in,
  output logic        hci_ack_out,
  output logic [7:0]  hci_d_out,
  output logic [15:0] mc_a_out,
  output logic        mc_r_nw_out,
  output logic [7:0]  mc_d_out,
  input  logic [7:0]  mc_d_in
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STEAL   = 2'd1,
    CAPTURE = 2'd2,
    GUARD   = 2'd3
  } state_e;

  localparam int unsigned GUARD_LOAD_I = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;
  localparam logic [3:0]  GUARD_LOAD   = GUARD_LOAD_I[3:0];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] lat_a_q, lat_a_d;
  logic        lat_r_nw_q, lat_r_nw_d;
  logic [7:0]  lat_d_q, lat_d_d;
  logic        ack_q, ack_d;
  logic [7:0]  rd_q, rd_d;
  logic        take_grant;
  logic        brk;

  // Next-state logic. The final guard cycle behaves like IDLE (grant allowed at
  // its closing edge), so the CPU runs exactly GUARD_CYCLES cycles between steals.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_a_d    = lat_a_q;
    lat_r_nw_d = lat_r_nw_q;
    lat_d_d    = lat_d_q;
    ack_d      = 1'b0;
    rd_d       = rd_q;
    take_grant = 1'b0;

    case (state_q)
      IDLE: begin
        if (hci_active_in) begin
          cnt_d = 4'd0;
        end else if (hci_req_in) begin
          take_grant = 1'b1;
        end
      end
      STEAL: begin
        state_d = CAPTURE;
        ack_d   = 1'b1;
      end
      CAPTURE: begin
        if (lat_r_nw_q) begin
          rd_d = mc_d_in;
        end
        cnt_d = 4'd0;
        if (hci_active_in) begin
          state_d = IDLE;
        end else if (GUARD_CYCLES == 0) begin
          if (hci_req_in) begin
            take_grant = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = GUARD;
          cnt_d   = GUARD_LOAD;
        end
      end
      GUARD: begin
        if (hci_active_in) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          if (hci_req_in) begin
            take_grant = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (take_grant) begin
      state_d    = STEAL;
      lat_a_d    = hci_a_in;
      lat_r_nw_d = hci_r_nw_in;
      lat_d_d    = hci_d_in;
    end
  end

  always_ff @(posedge clk_in or negedge nres_in) begin
    if (!nres_in) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      lat_a_q    <= 16'h0000;
      lat_r_nw_q <= 1'b0;
      lat_d_q    <= 8'h00;
      ack_q      <= 1'b0;
      rd_q       <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_a_q    <= lat_a_d;
      lat_r_nw_q <= lat_r_nw_d;
      lat_d_q    <= lat_d_d;
      ack_q      <= ack_d;
      rd_q       <= rd_d;
    end
  end

  // Break only takes the bus from a CPU-owned state; an in-flight steal completes first.
  assign brk = hci_active_in && ((state_q == IDLE) || (state_q == GUARD));

  always_comb begin
    mc_a_out    = cpu_a_in;
    mc_r_nw_out = cpu_r_nw_in;
    mc_d_out    = cpu_d_in;
    cpu_rdy_out = 1'b1;

    case (state_q)
      STEAL: begin
        mc_a_out    = lat_a_q;
        mc_r_nw_out = lat_r_nw_q;
        mc_d_out    = lat_d_q;
        cpu_rdy_out = 1'b0;
      end
      CAPTURE: begin
        mc_r_nw_out = 1'b1;
        cpu_rdy_out = 1'b0;
      end
      default: begin
        if (brk) begin
          mc_a_out    = hci_a_in;
          mc_r_nw_out = hci_r_nw_in;
          mc_d_out    = hci_d_in;
          cpu_rdy_out = 1'b0;
        end
      end
    endcase

    // No spurious write strobes reach the slaves while reset is held.
    if (!nres_in) begin
      mc_a_out    = cpu_a_in;
      mc_r_nw_out = 1'b1;
      mc_d_out    = cpu_d_in;
      cpu_rdy_out = 1'b1;
    end
  end

  // Read data is forwarded during the ack cycle, then held in rd_q.
  assign hci_d_out   = ((state_q == CAPTURE) && lat_r_nw_q) ? mc_d_in : rd_q;
  assign hci_ack_out = ack_q;

endmodule

// File: tb/tb_cpumc_arb.sv
// Directed bench for cpumc_arb: two instances (GUARD_CYCLES=2 and 0) share
// stimulus; each has its own synchronous-read memory model on the mc bus.
module tb_cpumc_arb;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        nres;
  logic [15:0] cpu_a;
  logic        cpu_r_nw;
  logic [7:0]  cpu_d;
  logic        act, req;
  logic [15:0] hci_a;
  logic        hci_r_nw;
  logic [7:0]  hci_d;

  logic        rdy0, ack0, rnw0, rdy1, ack1, rnw1;
  logic [7:0]  hd0, md0, hd1, md1;
  logic [15:0] ma0, ma1;
  logic [7:0]  di0, di1;

  logic        pre_we;
  logic [15:0] pre_a;
  logic [7:0]  pre_d;
  logic [7:0]  mem0 [0:65535];
  logic [7:0]  mem1 [0:65535];

  int checks = 0;
  int errors = 0;

  cpumc_arb #(.GUARD_CYCLES(2)) dut0 (
    .clk_in(clk), .nres_in(nres),
    .cpu_a_in(cpu_a), .cpu_r_nw_in(cpu_r_nw), .cpu_d_in(cpu_d), .cpu_rdy_out(rdy0),
    .hci_active_in(act), .hci_req_in(req), .hci_a_in(hci_a), .hci_r_nw_in(hci_r_nw),
    .hci_d_in(hci_d), .hci_ack_out(ack0), .hci_d_out(hd0),
    .mc_a_out(ma0), .mc_r_nw_out(rnw0), .mc_d_out(md0), .mc_d_in(di0)
  );

  cpumc_arb #(.GUARD_CYCLES(0)) dut1 (
    .clk_in(clk), .nres_in(nres),
    .cpu_a_in(cpu_a), .cpu_r_nw_in(cpu_r_nw), .cpu_d_in(cpu_d), .cpu_rdy_out(rdy1),
    .hci_active_in(act), .hci_req_in(req), .hci_a_in(hci_a), .hci_r_nw_in(hci_r_nw),
    .hci_d_in(hci_d), .hci_ack_out(ack1), .hci_d_out(hd1),
    .mc_a_out(ma1), .mc_r_nw_out(rnw1), .mc_d_out(md1), .mc_d_in(di1)
  );

  always @(posedge clk) begin
    if (pre_we) mem0[pre_a] <= pre_d;
    else if (!rnw0) mem0[ma0] <= md0;
    di0 <= mem0[ma0];
  end

  always @(posedge clk) begin
    if (pre_we) mem1[pre_a] <= pre_d;
    else if (!rnw1) mem1[ma1] <= md1;
    di1 <= mem1[ma1];
  end

  typedef struct {
    logic        act;
    logic        req;
    logic [15:0] ca;
    logic        crnw;
    logic [7:0]  cd;
    logic [15:0] ha;
    logic        hrnw;
    logic [7:0]  hd;
    logic [15:0] ea;
    logic        ernw;
    logic [7:0]  ed;
    logic        erdy;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 16'h8000, 1'b1, 8'h11, 16'h0200, 1'b0, 8'h22, 16'h8000, 1'b1, 8'h11, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 16'h0300, 1'b0, 8'h33, 16'h0400, 1'b1, 8'h44, 16'h0300, 1'b0, 8'h33, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 16'h8000, 1'b1, 8'h11, 16'h0200, 1'b0, 8'h22, 16'h0200, 1'b0, 8'h22, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 16'h0300, 1'b0, 8'h33, 16'h0400, 1'b1, 8'h44, 16'h0400, 1'b1, 8'h44, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 16'hFFFC, 1'b1, 8'h00, 16'h2002, 1'b1, 8'h00, 16'h2002, 1'b1, 8'h00, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 16'hFFFC, 1'b1, 8'h00, 16'h2002, 1'b0, 8'h00, 16'hFFFC, 1'b1, 8'h00, 1'b1};

    // Reset state, with the CPU trying to write: strobe must stay high
    nres = 1'b0; cpu_a = 16'h1234; cpu_r_nw = 1'b0; cpu_d = 8'h99;
    act = 1'b0; req = 1'b0; hci_a = 16'h0000; hci_r_nw = 1'b1; hci_d = 8'h00;
    pre_we = 1'b1; pre_a = 16'h0123; pre_d = 8'h5A;
    #3;
    chk("rst_rdy", 16'(rdy0), 16'h1);
    chk("rst_ack", 16'(ack0), 16'h0);
    chk("rst_hd", 16'(hd0), 16'h00);
    chk("rst_ma", ma0, 16'h1234);
    chk("rst_rnw", 16'(rnw0), 16'h1);
    step();
    pre_we = 1'b0; cpu_r_nw = 1'b1;
    step();
    nres = 1'b1;
    step();

    // Idle and break bus muxing
    for (int i = 0; i < 6; i++) begin
      act = tbl[i].act; req = tbl[i].req;
      cpu_a = tbl[i].ca; cpu_r_nw = tbl[i].crnw; cpu_d = tbl[i].cd;
      hci_a = tbl[i].ha; hci_r_nw = tbl[i].hrnw; hci_d = tbl[i].hd;
      #1;
      chk($sformatf("tbl%0d_ma", i), ma0, tbl[i].ea);
      chk($sformatf("tbl%0d_rnw", i), 16'(rnw0), 16'(tbl[i].ernw));
      chk($sformatf("tbl%0d_md", i), 16'(md0), 16'(tbl[i].ed));
      chk($sformatf("tbl%0d_rdy", i), 16'(rdy0), 16'(tbl[i].erdy));
      step();
      chk($sformatf("tbl%0d_ack", i), 16'(ack0), 16'h0);
    end
    act = 1'b0; req = 1'b0; cpu_r_nw = 1'b1;
    step();

    // HCI read of 0x0123 while CPU reads 0x8000
    cpu_a = 16'h8000; hci_a = 16'h0123; hci_r_nw = 1'b1; req = 1'b1;
    #1;
    chk("rd_c0_rdy", 16'(rdy0), 16'h1);
    step();
    chk("rd_c1_ma", ma0, 16'h0123);
    chk("rd_c1_rdy", 16'(rdy0), 16'h0);
    chk("rd_c1_ack", 16'(ack0), 16'h0);
    step();
    req = 1'b0;
    #1;
    chk("rd_c2_ma", ma0, 16'h8000);
    chk("rd_c2_rnw", 16'(rnw0), 16'h1);
    chk("rd_c2_rdy", 16'(rdy0), 16'h0);
    chk("rd_c2_ack", 16'(ack0), 16'h1);
    chk("rd_c2_hd", 16'(hd0), 16'h5A);
    chk("rd_c2_ack_g0", 16'(ack1), 16'h1);
    step();
    chk("rd_c3_rdy", 16'(rdy0), 16'h1);
    chk("rd_c3_ack", 16'(ack0), 16'h0);
    chk("rd_c3_hd", 16'(hd0), 16'h5A);
    repeat (3) step();

    // HCI write 0x0010 <- A5, then CPU reads it back
    hci_a = 16'h0010; hci_r_nw = 1'b0; hci_d = 8'hA5; req = 1'b1;
    #1;
    chk("wr_c0_rnw", 16'(rnw0), 16'h1);
    step();
    chk("wr_c1_rnw", 16'(rnw0), 16'h0);
    chk("wr_c1_ma", ma0, 16'h0010);
    chk("wr_c1_md", 16'(md0), 16'hA5);
    step();
    req = 1'b0;
    #1;
    chk("wr_c2_rnw", 16'(rnw0), 16'h1);
    chk("wr_c2_ack", 16'(ack0), 16'h1);
    chk("wr_c2_hd", 16'(hd0), 16'h5A);
    step();
    cpu_a = 16'h0010;
    chk("wr_c3_rnw", 16'(rnw0), 16'h1);
    step();
    chk("wr_readback", 16'(di0), 16'hA5);
    repeat (3) step();

    // Request held high: steal cadence for both guard settings
    cpu_a = 16'h8000; hci_a = 16'h0123; hci_r_nw = 1'b1; req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk($sformatf("held%0d_rdy_g2", c), 16'(rdy0), 16'(((c - 1) % 4) >= 2));
      chk($sformatf("held%0d_ack_g2", c), 16'(ack0), 16'((c % 4) == 2));
      chk($sformatf("held%0d_rdy_g0", c), 16'(rdy1), 16'h0);
      chk($sformatf("held%0d_ack_g0", c), 16'(ack1), 16'((c % 2) == 0));
      if (c == 8) req = 1'b0;
    end
    repeat (3) step();

    // Break: HCI owns bus, requests ignored, no ack
    act = 1'b1; req = 1'b1; hci_r_nw = 1'b1;
    for (int c = 0; c < 10; c++) begin
      hci_a = 16'h6000 + 16'(c * 3);
      #1;
      chk($sformatf("brk%0d_ma", c), ma0, 16'h6000 + 16'(c * 3));
      chk($sformatf("brk%0d_rdy", c), 16'(rdy0), 16'h0);
      chk($sformatf("brk%0d_ack", c), 16'(ack0), 16'h0);
      step();
    end
    act = 1'b0; req = 1'b0;
    step();

    // Break asserted during STEAL: access completes and acks first
    hci_a = 16'h0123; hci_r_nw = 1'b1; req = 1'b1;
    step();
    act = 1'b1; req = 1'b0; hci_a = 16'h4444;
    #1;
    chk("bs_c1_ma", ma0, 16'h0123);
    chk("bs_c1_rdy", 16'(rdy0), 16'h0);
    step();
    chk("bs_c2_ack", 16'(ack0), 16'h1);
    chk("bs_c2_hd", 16'(hd0), 16'h5A);
    step();
    chk("bs_c3_ma", ma0, 16'h4444);
    chk("bs_c3_ack", 16'(ack0), 16'h0);
    chk("bs_c3_rdy", 16'(rdy0), 16'h0);
    act = 1'b0;
    step();
    chk("bs_c4_rdy", 16'(rdy0), 16'h1);

    // Reset during STEAL
    cpu_a = 16'h9000; cpu_r_nw = 1'b0; cpu_d = 8'h77;
    hci_a = 16'h0123; hci_r_nw = 1'b1; req = 1'b1;
    step();
    chk("rs_c1_ma", ma0, 16'h0123);
    nres = 1'b0; req = 1'b0;
    #1;
    chk("rs_rdy", 16'(rdy0), 16'h1);
    chk("rs_ack", 16'(ack0), 16'h0);
    chk("rs_ma", ma0, 16'h9000);
    chk("rs_rnw", 16'(rnw0), 16'h1);
    chk("rs_hd", 16'(hd0), 16'h00);
    step();
    chk("rs_ack_next", 16'(ack0), 16'h0);
    nres = 1'b1; cpu_r_nw = 1'b1;
    step();
    hci_a = 16'h0010; hci_r_nw = 1'b1; req = 1'b1;
    #1;
    chk("rs_post_rdy", 16'(rdy0), 16'h1);
    step();
    chk("rs_post_c1_ma", ma0, 16'h0010);
    chk("rs_post_c1_rdy", 16'(rdy0), 16'h0);
    step();
    req = 1'b0;
    chk("rs_post_c2_ack", 16'(ack0), 16'h1);
    chk("rs_post_c2_hd", 16'(hd0), 16'hA5);
    step();
    chk("rs_post_c3_ack", 16'(ack0), 16'h0);
    chk("rs_post_c3_hd", 16'(hd0), 16'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
